// File: rtl/victim_buffer_plru.sv
// Fully-associative victim buffer with tree pseudo-LRU replacement, ready/valid writeback and a flush engine.
// Optional feature: define VICTIM_EXCLUSIVE_EN so a lookup hit invalidates the entry instead of touching PLRU.
module victim_buffer_plru #(
  parameter int ENTRIES     = 4,
  parameter int LINE_BITS   = 256,
  parameter int ADDR_BITS   = 32,
  parameter int OFFSET_BITS = 5
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 lookupValid,
  input  logic [ADDR_BITS-1:0] lookupAddr,
  output logic                 respValid,
  output logic                 hit,
  output logic [7:0]           dataReturn,
  output logic [LINE_BITS-1:0] memDataOut,
  input  logic                 insValid,
  output logic                 insReady,
  input  logic [ADDR_BITS-1:0] insAddr,
  input  logic [LINE_BITS-1:0] insData,
  output logic                 evictValid,
  input  logic                 evictReady,
  output logic [ADDR_BITS-1:0] evictAddr,
  output logic [LINE_BITS-1:0] evictData,
  input  logic                 flushReq,
  output logic                 flushDone
);

  localparam int TAG_BITS = ADDR_BITS - OFFSET_BITS;
  localparam int IDX_BITS = $clog2(ENTRIES);

`ifdef VICTIM_EXCLUSIVE_EN
  localparam bit EXCLUSIVE = 1'b1;
`else
  localparam bit EXCLUSIVE = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, FLUSH, DRAIN} state_t;
  typedef logic [ENTRIES-1:1] tree_t;
  typedef logic [IDX_BITS-1:0] idx_t;

  // Heap-numbered tree: node 1 is the root, leaf for entry i is node ENTRIES+i.
  function automatic tree_t touch(input tree_t t_in, input idx_t i);
    tree_t t;
    logic [IDX_BITS:0] node;
    idx_t parent;
    t    = t_in;
    node = {1'b1, i};
    for (int k = 0; k < IDX_BITS; k++) begin
      parent    = node[IDX_BITS:1];
      t[parent] = ~node[0];
      node      = {1'b0, parent};
    end
    return t;
  endfunction

  function automatic idx_t plru_victim(input tree_t t);
    logic [IDX_BITS:0] node;
    node = (IDX_BITS+1)'(1);
    for (int k = 0; k < IDX_BITS; k++) begin
      node = {node[IDX_BITS-1:0], t[node[IDX_BITS-1:0]]};
    end
    return node[IDX_BITS-1:0];
  endfunction

  state_t state, state_d;
  idx_t flush_idx, flush_idx_d;
  logic flush_load, done_d;

  logic [ENTRIES-1:0] valid, valid_d;
  tree_t plru, plru_d;
  logic [TAG_BITS-1:0] tags [ENTRIES];
  logic [LINE_BITS-1:0] lines [ENTRIES];

  logic [TAG_BITS-1:0] lk_tag, ins_tag;
  logic [OFFSET_BITS-1:0] lk_off;
  logic lk_hit, ins_dup, has_free, ins_fire, ins_evict;
  idx_t lk_idx, dup_idx, free_idx, ins_idx;
  logic [LINE_BITS-1:0] lk_line;
  logic [7:0] lk_byte;

  logic unused_ins_offset;
  assign unused_ins_offset = ^insAddr[OFFSET_BITS-1:0];

  assign lk_tag   = lookupAddr[ADDR_BITS-1:OFFSET_BITS];
  assign lk_off   = lookupAddr[OFFSET_BITS-1:0];
  assign ins_tag  = insAddr[ADDR_BITS-1:OFFSET_BITS];
  assign insReady = (state == IDLE) && !evictValid;
  assign ins_fire = insValid && insReady;

  always_comb begin
    lk_hit  = 1'b0;
    lk_idx  = '0;
    lk_line = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (lookupValid && valid[i] && tags[i] == lk_tag) begin
        lk_hit  = 1'b1;
        lk_idx  = idx_t'(i);
        lk_line = lines[i];
      end
    end
    lk_byte = lk_line[LINE_BITS-1-8*int'(lk_off) -: 8];
  end

  // Slot choice: existing copy of the tag, else lowest free slot, else the PLRU victim.
  always_comb begin
    ins_dup  = 1'b0;
    dup_idx  = '0;
    has_free = 1'b0;
    free_idx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid[i] && tags[i] == ins_tag) begin
        ins_dup = 1'b1;
        dup_idx = idx_t'(i);
      end
    end
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        has_free = 1'b1;
        free_idx = idx_t'(i);
      end
    end
    ins_idx   = ins_dup ? dup_idx : (has_free ? free_idx : plru_victim(plru));
    ins_evict = ins_fire && !ins_dup && valid[ins_idx] &&
                !(EXCLUSIVE && lk_hit && lk_idx == ins_idx);
  end

  always_comb begin
    state_d     = state;
    flush_idx_d = flush_idx;
    flush_load  = 1'b0;
    done_d      = 1'b0;
    case (state)
      IDLE: begin
        if (flushReq) begin
          state_d     = FLUSH;
          flush_idx_d = '0;
        end
      end
      FLUSH: begin
        if (!valid[flush_idx] || (EXCLUSIVE && lk_hit && lk_idx == flush_idx) || !evictValid) begin
          flush_load = valid[flush_idx] && !(EXCLUSIVE && lk_hit && lk_idx == flush_idx);
          if (flush_idx == idx_t'(ENTRIES - 1)) state_d = DRAIN;
          else flush_idx_d = flush_idx + 1'b1;
        end
      end
      DRAIN: begin
        if (!evictValid) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Lookup effects apply before insert effects so the insert wins on the same entry.
  always_comb begin
    valid_d = valid;
    plru_d  = plru;
    if (lk_hit) begin
      if (EXCLUSIVE) valid_d[lk_idx] = 1'b0;
      else plru_d = touch(plru_d, lk_idx);
    end
    if (flush_load) valid_d[flush_idx] = 1'b0;
    if (ins_fire) begin
      valid_d[ins_idx] = 1'b1;
      plru_d = touch(plru_d, ins_idx);
    end
    if (state == DRAIN && state_d == IDLE) plru_d = '0;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      flush_idx  <= '0;
      valid      <= '0;
      plru       <= '0;
      respValid  <= 1'b0;
      hit        <= 1'b0;
      dataReturn <= '0;
      memDataOut <= '0;
      evictValid <= 1'b0;
      evictAddr  <= '0;
      evictData  <= '0;
      flushDone  <= 1'b0;
    end else begin
      state      <= state_d;
      flush_idx  <= flush_idx_d;
      valid      <= valid_d;
      plru       <= plru_d;
      respValid  <= lookupValid;
      hit        <= lk_hit;
      dataReturn <= lk_byte;
      memDataOut <= lk_line;
      flushDone  <= done_d;
      if (evictValid && evictReady) evictValid <= 1'b0;
      if (ins_evict) begin
        evictValid <= 1'b1;
        evictAddr  <= {tags[ins_idx], {OFFSET_BITS{1'b0}}};
        evictData  <= lines[ins_idx];
      end else if (flush_load) begin
        evictValid <= 1'b1;
        evictAddr  <= {tags[flush_idx], {OFFSET_BITS{1'b0}}};
        evictData  <= lines[flush_idx];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (ins_fire) begin
      tags[ins_idx]  <= ins_tag;
      lines[ins_idx] <= insData;
    end
  end

endmodule

// File: tb/tb_victim_buffer_plru.sv
// Directed bench for victim_buffer_plru: lookup responses are checked through a scoreboard queue,
// writebacks are logged by a monitor and compared against the expected order.
module tb_victim_buffer_plru;

  localparam int ENTRIES = 4;
  localparam int LINE_BITS = 256;
  localparam int ADDR_BITS = 32;
  localparam int OFFSET_BITS = 5;

  logic CLK = 1'b0;
  logic RST;
  logic lookupValid;
  logic [ADDR_BITS-1:0] lookupAddr;
  logic respValid, hit;
  logic [7:0] dataReturn;
  logic [LINE_BITS-1:0] memDataOut;
  logic insValid, insReady;
  logic [ADDR_BITS-1:0] insAddr;
  logic [LINE_BITS-1:0] insData;
  logic evictValid, evictReady;
  logic [ADDR_BITS-1:0] evictAddr;
  logic [LINE_BITS-1:0] evictData;
  logic flushReq, flushDone;

  int errors = 0;
  int checks = 0;
  int pulses;

  typedef struct packed {
    logic hit;
    logic [7:0] data;
    logic [LINE_BITS-1:0] line;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic [ADDR_BITS-1:0] wb_addrs[$];

  victim_buffer_plru #(
    .ENTRIES(ENTRIES), .LINE_BITS(LINE_BITS), .ADDR_BITS(ADDR_BITS), .OFFSET_BITS(OFFSET_BITS)
  ) dut (
    .CLK(CLK), .RST(RST),
    .lookupValid(lookupValid), .lookupAddr(lookupAddr),
    .respValid(respValid), .hit(hit), .dataReturn(dataReturn), .memDataOut(memDataOut),
    .insValid(insValid), .insReady(insReady), .insAddr(insAddr), .insData(insData),
    .evictValid(evictValid), .evictReady(evictReady), .evictAddr(evictAddr), .evictData(evictData),
    .flushReq(flushReq), .flushDone(flushDone)
  );

  always #5 CLK = ~CLK;

  function automatic logic [LINE_BITS-1:0] pat(input int seed);
    logic [LINE_BITS-1:0] p;
    for (int b = 0; b < LINE_BITS / 8; b++) p[8*b +: 8] = 8'(seed * 37 + b * 5 + 1);
    return p;
  endfunction

  // Offset 0 addresses the most significant byte of the line.
  function automatic logic [7:0] exp_byte(input logic [LINE_BITS-1:0] line, input int off);
    logic [LINE_BITS-1:0] s;
    s = line >> (8 * (LINE_BITS / 8 - 1 - off));
    return s[7:0];
  endfunction

  task automatic check_output(input string name, input logic [LINE_BITS-1:0] obs,
                              input logic [LINE_BITS-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: got %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset();
    tick();
    RST = 1'b1;
    lookupValid = 1'b0;
    insValid = 1'b0;
    flushReq = 1'b0;
    tick();
    tick();
    RST = 1'b0;
    tick();
  endtask

  task automatic apply_insert(input logic [ADDR_BITS-1:0] addr, input logic [LINE_BITS-1:0] data);
    int w;
    w = 0;
    while (!insReady && w < 50) begin
      tick();
      w++;
    end
    if (!insReady) check_output("ins_ready_timeout", LINE_BITS'(insReady), 1);
    insValid = 1'b1;
    insAddr = addr;
    insData = data;
    tick();
    insValid = 1'b0;
  endtask

  task automatic apply_lookup(input logic [ADDR_BITS-1:0] addr, input logic exp_hit,
                              input logic [LINE_BITS-1:0] exp_line);
    exp_t e;
    e.hit  = exp_hit;
    e.line = exp_hit ? exp_line : '0;
    e.data = exp_hit ? exp_byte(exp_line, int'(addr[OFFSET_BITS-1:0])) : 8'h00;
    sb.push_back(e);
    lookupValid = 1'b1;
    lookupAddr = addr;
    tick();
    lookupValid = 1'b0;
  endtask

  // Response scoreboard and writeback logger.
  always @(negedge CLK) begin
    if (!RST) begin
      if (respValid) begin
        if (sb.size() == 0) begin
          check_output("resp_unexpected", LINE_BITS'(respValid), '0);
        end else begin
          mon_e = sb.pop_front();
          check_output("resp_hit", LINE_BITS'(hit), LINE_BITS'(mon_e.hit));
          check_output("resp_byte", LINE_BITS'(dataReturn), LINE_BITS'(mon_e.data));
          check_output("resp_line", memDataOut, mon_e.line);
        end
      end
      if (evictValid && evictReady) wb_addrs.push_back(evictAddr);
    end
  end

  initial begin
    RST = 1'b1;
    lookupValid = 1'b0;
    lookupAddr = '0;
    insValid = 1'b0;
    insAddr = '0;
    insData = '0;
    evictReady = 1'b0;
    flushReq = 1'b0;
    #2;
    $display("[TB] reset values");
    check_output("rst_respValid", LINE_BITS'(respValid), 0);
    check_output("rst_hit", LINE_BITS'(hit), 0);
    check_output("rst_dataReturn", LINE_BITS'(dataReturn), 0);
    check_output("rst_memDataOut", memDataOut, 0);
    check_output("rst_evictValid", LINE_BITS'(evictValid), 0);
    check_output("rst_evictAddr", LINE_BITS'(evictAddr), 0);
    check_output("rst_evictData", evictData, 0);
    check_output("rst_flushDone", LINE_BITS'(flushDone), 0);
    check_output("rst_insReady", LINE_BITS'(insReady), 1);
    tick();
    RST = 1'b0;
    tick();

    $display("[TB] insert then byte lookup");
    evictReady = 1'b1;
    apply_insert(32'h100, pat(1));
    apply_lookup(32'h103, 1'b1, pat(1));
`ifdef VICTIM_EXCLUSIVE_EN
    apply_lookup(32'h100, 1'b0, '0);
`else
    apply_lookup(32'h100, 1'b1, pat(1));
`endif
    apply_lookup(32'h200, 1'b0, '0);

    $display("[TB] fifth insert evicts first");
    apply_reset();
    evictReady = 1'b1;
    apply_insert(32'h100, pat(10));
    apply_insert(32'h200, pat(11));
    apply_insert(32'h300, pat(12));
    apply_insert(32'h400, pat(13));
    check_output("fill_no_evict", LINE_BITS'(evictValid), 0);
    apply_insert(32'h51F, pat(14));
    check_output("evict5_valid", LINE_BITS'(evictValid), 1);
    check_output("evict5_addr", LINE_BITS'(evictAddr), LINE_BITS'(32'h100));
    check_output("evict5_data", evictData, pat(10));
    check_output("evict5_insReady", LINE_BITS'(insReady), 0);
    tick();
    check_output("evict5_drop", LINE_BITS'(evictValid), 0);
    apply_lookup(32'h100, 1'b0, '0);
    apply_lookup(32'h510, 1'b1, pat(14));

    $display("[TB] hit steers PLRU victim");
    apply_reset();
    evictReady = 1'b1;
    apply_insert(32'h1000, pat(20));
    apply_insert(32'h2000, pat(21));
    apply_insert(32'h3000, pat(22));
    apply_insert(32'h4000, pat(23));
    apply_lookup(32'h1000, 1'b1, pat(20));
    apply_insert(32'h5000, pat(24));
`ifdef VICTIM_EXCLUSIVE_EN
    check_output("plru_evict_valid", LINE_BITS'(evictValid), 0);
`else
    check_output("plru_evict_valid", LINE_BITS'(evictValid), 1);
    check_output("plru_evict_addr", LINE_BITS'(evictAddr), LINE_BITS'(32'h3000));
    check_output("plru_evict_data", evictData, pat(22));
`endif

    $display("[TB] evict backpressure");
    apply_reset();
    evictReady = 1'b0;
    apply_insert(32'h100, pat(30));
    apply_insert(32'h200, pat(31));
    apply_insert(32'h300, pat(32));
    apply_insert(32'h400, pat(33));
    apply_insert(32'h500, pat(34));
    for (int c = 0; c < 3; c++) begin
      check_output("bp_valid_held", LINE_BITS'(evictValid), 1);
      check_output("bp_data_held", evictData, pat(30));
      check_output("bp_insReady", LINE_BITS'(insReady), 0);
      tick();
    end
    wb_addrs.delete();
    evictReady = 1'b1;
    tick();
    check_output("bp_released", LINE_BITS'(evictValid), 0);
    check_output("bp_insReady_back", LINE_BITS'(insReady), 1);
    tick();
    check_output("bp_one_handshake", LINE_BITS'(wb_addrs.size()), 1);

    $display("[TB] flush with toggling evictReady");
    apply_reset();
    evictReady = 1'b1;
    apply_insert(32'h100, pat(40));
    apply_insert(32'h200, pat(41));
    apply_insert(32'h300, pat(42));
    tick();
    wb_addrs.delete();
    flushReq = 1'b1;
    tick();
    flushReq = 1'b0;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      evictReady = ~evictReady;
      tick();
      if (flushDone) pulses++;
    end
    evictReady = 1'b1;
    check_output("flush_done_pulses", LINE_BITS'(pulses), 1);
    check_output("flush_wb_count", LINE_BITS'(wb_addrs.size()), 3);
    for (int k = 0; k < 3; k++) begin
      check_output($sformatf("flush_wb_addr%0d", k),
                   (k < wb_addrs.size()) ? LINE_BITS'(wb_addrs[k]) : {LINE_BITS{1'bx}},
                   LINE_BITS'(32'h100 * (k + 1)));
    end
    check_output("flush_insReady", LINE_BITS'(insReady), 1);
    apply_lookup(32'h100, 1'b0, '0);
    apply_lookup(32'h200, 1'b0, '0);
    apply_lookup(32'h300, 1'b0, '0);

    $display("[TB] duplicate tag overwrite");
    apply_reset();
    evictReady = 1'b1;
    apply_insert(32'h700, pat(50));
    apply_insert(32'h710, pat(51));
    check_output("dup_no_evict", LINE_BITS'(evictValid), 0);
    apply_lookup(32'h705, 1'b1, pat(51));

    tick();
    tick();
    check_output("sb_drained", LINE_BITS'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
